pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard, forwarding and pipeline-control unit for the 5-stage RISC-V pipeline. It replaces the separate load-use detector and forwarding unit with one block that also handles three further cases. A variable-latency data memory freezes the pipe through a ready handshake, with a timeout. Branch flushes are gated correctly against freezes. A register scoreboard supports a multi-cycle MUL/DIV unit. It sits beside the datapath and drives every stall, flush and bubble signal, plus the forwarding mux selects.

## Interface
Parameters:
- NREG, 32, number of architectural registers; RA_W = $clog2(NREG)
- MEM_TIMEOUT, 64, maximum wait cycles for dmem_ready before abort (≥2)
- CNT_W, 32, width of the stall-cycle performance counter

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_rs1, id_rs2, id_rd  in  RA_W each  register fields of the instruction in ID
- id_use_rs1, id_use_rs2, id_regwrite  in  1 each  ID operand-use and write flags
- ex_rs1, ex_rs2, ex_rd  in  RA_W each  register fields held in ID/EX
- ex_regwrite, ex_memread  in  1 each  ID/EX control bits
- mem_rd  in  RA_W; mem_regwrite  in  1  EX/MEM destination
- wb_rd  in  RA_W; wb_regwrite  in  1  MEM/WB destination
- br_taken  in  1  branch/jump resolved taken in EX
- dmem_req  in  1  EX/MEM holds a load or store
- dmem_ready  in  1  data memory completes this cycle
- mdu_issue  in  1  EX issues a multi-cycle op writing ex_rd
- mdu_done  in  1; mdu_rd  in  RA_W  MDU writeback
- fwd_a, fwd_b  out  2 each  operand select: 00 regfile, 01 WB, 10 MEM, 11 unused
- stall_pc, stall_if_id  out  1 each  hold PC and IF/ID
- bubble_id_ex  out  1  load NOP into ID/EX
- flush_if_id, flush_id_ex  out  1 each  clear the register
- freeze  out  1  hold ID/EX and EX/MEM, bubble into MEM/WB
- mem_abort  out  1  one-cycle pulse when a timeout completes the access
- dmem_timeout  out  1  sticky error flag
- stall_cnt  out  CNT_W  cycles with stall_pc asserted, saturating

## Operation
- Register 0 never forwards, never hazards, and is never scoreboarded.
- **Forwarding:**
  - fwd_a = 10 if mem_regwrite and mem_rd == ex_rs1 ≠ 0.
  - Otherwise 01 if wb_regwrite and wb_rd == ex_rs1 ≠ 0.
  - Otherwise 00.
  - fwd_b is derived the same way from ex_rs2. MEM has priority over WB.
- **Load-use:** ex_memread, ex_rd ≠ 0, and ex_rd matches a used ID source. Response: stall_pc, stall_if_id and bubble_id_ex.
- **Memory FSM**, states IDLE and WAIT; wait_cnt is sized for MEM_TIMEOUT.
  - IDLE: dmem_req and not dmem_ready gives freeze=1, go to WAIT with wait_cnt=1.
  - WAIT: freeze=1 while not dmem_ready, and wait_cnt increments.
  - WAIT with dmem_ready: freeze=0 that cycle, go to IDLE.
  - WAIT with wait_cnt == MEM_TIMEOUT-1 and not ready: mem_abort=1 and freeze=0; dmem_timeout is set; go to IDLE.
- **freeze:** also forces stall_pc and stall_if_id, and suppresses bubble_id_ex and both flushes.
- **Branch:** br_taken and not freeze gives flush_if_id and flush_id_ex. Any load-use or scoreboard stall in the same cycle is dropped.
- **Priority**, highest first: reset, freeze, branch flush, scoreboard stall, load-use stall.
- **stall_cnt** increments each cycle stall_pc=1 and holds at its all-ones value.

## Timing
- All control outputs are combinational from inputs and registered state, so their latency is zero. State updates on the rising clk edge.
- While reset=1, outputs are: flush_if_id=1 and flush_id_ex=1; every other control output 0; fwd 00.
- Reset state:
  - FSM in IDLE, wait_cnt=0.
  - dmem_timeout=0, stall_cnt=0, scoreboard cleared.
- Reset asserted mid-WAIT returns to IDLE at the next edge with no mem_abort.
- dmem_ready in the same cycle as the timeout: ready wins, no abort.
- An access that is ready in the same cycle as dmem_req never enters WAIT and never freezes.

## Configuration
- HAZ_MDU_EN defined:
  - An NREG-bit pending scoreboard is present.
  - mdu_issue with ex_rd ≠ 0 and not freeze sets pending[ex_rd]. mdu_done clears pending[mdu_rd].
  - When the same register is set and cleared in one cycle, set wins.
  - ID stalls (stall_pc, stall_if_id, bubble_id_ex) if a used source is pending (RAW), or if id_regwrite and id_rd is pending (WAW).
- HAZ_MDU_EN undefined: no scoreboard. mdu_issue, mdu_done and mdu_rd are ignored and never cause a stall.

## Test plan
- ex_memread=1, ex_rd=5, id_rs1=5 used -> stall_pc=1, bubble_id_ex=1 for one cycle. Same case with ex_rd=0 -> no stall.
- mem_rd=wb_rd=7, both regwrite, ex_rs1=7 -> fwd_a=10. Clear mem_regwrite -> fwd_a=01.
- dmem_req=1 with dmem_ready low for 3 cycles, then high -> freeze=1 for exactly 3 cycles; stall_cnt rises by 3.
- dmem_ready held low with MEM_TIMEOUT=8 -> freeze for 7 cycles, then mem_abort pulses and dmem_timeout stays 1 until reset.
- br_taken=1 during freeze -> no flush until the freeze releases. br_taken=1 together with a load-use hazard -> flushes asserted, stall_pc=0.
- With HAZ_MDU_EN: mdu_issue with ex_rd=9, then ID reads x9 -> stall until mdu_done with mdu_rd=9. Without the macro -> no stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// pipe_hazard_ctrl: operand forwarding, load-use/MDU stalls, branch flush, dmem freeze with timeout.
// Optional feature macro: HAZ_MDU_EN (MDU register scoreboard).  Rev 1.0
module pipe_hazard_ctrl #(
  parameter  int NREG        = 32,
  parameter  int MEM_TIMEOUT = 64,
  parameter  int CNT_W       = 32,
  localparam int RA_W        = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_regwrite,
  input  logic [RA_W-1:0] ex_rs1,
  input  logic [RA_W-1:0] ex_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic            br_taken,
  input  logic            dmem_req,
  input  logic            dmem_ready,
  input  logic            mdu_issue,
  input  logic            mdu_done,
  input  logic [RA_W-1:0] mdu_rd,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            stall_pc,
  output logic            stall_if_id,
  output logic            bubble_id_ex,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            freeze,
  output logic            mem_abort,
  output logic            dmem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int              WC_W      = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_e;

  mem_state_e       state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             frz, abort;
  logic             lu_haz, sb_haz;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    frz        = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (dmem_req && !dmem_ready) begin
          frz        = 1'b1;
          state_d    = WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      WAIT: begin
        // Ready takes precedence over an expiring timeout in the same cycle.
        if (dmem_ready) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          abort      = 1'b1;
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          frz        = 1'b1;
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d    = IDLE;
      wait_cnt_d = '0;
      frz        = 1'b0;
      abort      = 1'b0;
    end
  end

  assign lu_haz = ex_memread && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

`ifdef HAZ_MDU_EN
  logic [NREG-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (mdu_done && (mdu_rd != '0)) pend_d[mdu_rd] = 1'b0;
    if (mdu_issue && (ex_rd != '0) && !frz) pend_d[ex_rd] = 1'b1;
    if (reset) pend_d = '0;
  end

  always_ff @(posedge clk) pend_q <= pend_d;

  assign sb_haz = (id_use_rs1  && (id_rs1 != '0) && pend_q[id_rs1]) ||
                  (id_use_rs2  && (id_rs2 != '0) && pend_q[id_rs2]) ||
                  (id_regwrite && (id_rd  != '0) && pend_q[id_rd]);

  logic unused_in;
  assign unused_in = ex_regwrite;
`else
  assign sb_haz = 1'b0;

  logic unused_in;
  assign unused_in = ^{ex_regwrite, mdu_issue, mdu_done, mdu_rd, id_rd, id_regwrite};
`endif

  always_comb begin
    fwd_a = 2'b00;
    if (mem_regwrite && (mem_rd == ex_rs1) && (ex_rs1 != '0))     fwd_a = 2'b10;
    else if (wb_regwrite && (wb_rd == ex_rs1) && (ex_rs1 != '0))  fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (mem_regwrite && (mem_rd == ex_rs2) && (ex_rs2 != '0))     fwd_b = 2'b10;
    else if (wb_regwrite && (wb_rd == ex_rs2) && (ex_rs2 != '0))  fwd_b = 2'b01;

    stall_pc     = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    if (reset) begin
      flush_if_id = 1'b1;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
    end else if (frz) begin
      stall_pc = 1'b1;
    end else if (br_taken) begin
      flush_if_id = 1'b1;
    end else if (sb_haz || lu_haz) begin
      stall_pc     = 1'b1;
      bubble_id_ex = 1'b1;
    end
    stall_if_id = stall_pc;
    flush_id_ex = flush_if_id;
  end

  always_comb begin
    timeout_d   = reset ? 1'b0 : (timeout_q || abort);
    stall_cnt_d = stall_cnt_q;
    if (reset)                                 stall_cnt_d = '0;
    else if (stall_pc && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    wait_cnt_q  <= wait_cnt_d;
    timeout_q   <= timeout_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign freeze       = frz;
  assign mem_abort    = abort;
  assign dmem_timeout = timeout_q && !reset;
  assign stall_cnt    = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// tb_pipe_hazard_ctrl: table vectors, directed corner sequences and random stimulus vs a reference model.
// Rev 1.0
module tb_pipe_hazard_ctrl;
  localparam int NREG = 32;
  localparam int RA_W = 5;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W = 6;
`ifdef HAZ_MDU_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif

  typedef struct packed {
    logic            reset;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2, id_regwrite;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic            ex_regwrite, ex_memread;
    logic [RA_W-1:0] mem_rd;
    logic            mem_regwrite;
    logic [RA_W-1:0] wb_rd;
    logic            wb_regwrite;
    logic            br_taken, dmem_req, dmem_ready, mdu_issue, mdu_done;
    logic [RA_W-1:0] mdu_rd;
  } in_t;

  typedef struct packed {
    logic [1:0]       fwd_a, fwd_b;
    logic             stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex;
    logic             freeze, mem_abort, dmem_timeout;
    logic [CNT_W-1:0] stall_cnt;
  } out_t;

  typedef struct {
    in_t        i;
    logic [1:0] fa, fb;
    logic       stall, bubble, flush;
    string      nm;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, mdu_rd;
  logic id_use_rs1, id_use_rs2, id_regwrite, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic br_taken, dmem_req, dmem_ready, mdu_issue, mdu_done;
  logic [1:0] fwd_a, fwd_b;
  logic stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex, freeze, mem_abort, dmem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles the current access has waited, sticky error, counter, pending set.
  int          m_wait;
  bit          m_tout;
  int          m_cnt;
  bit [NREG-1:0] m_pend;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NREG(NREG), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_regwrite(id_regwrite),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .mdu_issue(mdu_issue), .mdu_done(mdu_done), .mdu_rd(mdu_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .freeze(freeze), .mem_abort(mem_abort), .dmem_timeout(dmem_timeout),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input out_t g, input out_t e);
    chk({tag, ".fwd_a"},        32'(g.fwd_a),        32'(e.fwd_a));
    chk({tag, ".fwd_b"},        32'(g.fwd_b),        32'(e.fwd_b));
    chk({tag, ".stall_pc"},     32'(g.stall_pc),     32'(e.stall_pc));
    chk({tag, ".stall_if_id"},  32'(g.stall_if_id),  32'(e.stall_if_id));
    chk({tag, ".bubble_id_ex"}, 32'(g.bubble_id_ex), 32'(e.bubble_id_ex));
    chk({tag, ".flush_if_id"},  32'(g.flush_if_id),  32'(e.flush_if_id));
    chk({tag, ".flush_id_ex"},  32'(g.flush_id_ex),  32'(e.flush_id_ex));
    chk({tag, ".freeze"},       32'(g.freeze),       32'(e.freeze));
    chk({tag, ".mem_abort"},    32'(g.mem_abort),    32'(e.mem_abort));
    chk({tag, ".dmem_timeout"}, 32'(g.dmem_timeout), 32'(e.dmem_timeout));
    chk({tag, ".stall_cnt"},    32'(g.stall_cnt),    32'(e.stall_cnt));
  endtask

  function automatic logic [1:0] ref_fwd(input in_t v, input logic [RA_W-1:0] rs);
    if (rs == 0) return 2'b00;
    if (v.mem_regwrite && v.mem_rd == rs) return 2'b10;
    if (v.wb_regwrite && v.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model_out(input in_t v);
    out_t o = '0;
    bit lu, sb, in_flight;
    o.stall_cnt = CNT_W'(m_cnt);
    if (v.reset) begin
      o.flush_if_id = 1'b1;
      o.flush_id_ex = 1'b1;
      return o;
    end
    o.dmem_timeout = m_tout;
    o.fwd_a = ref_fwd(v, v.ex_rs1);
    o.fwd_b = ref_fwd(v, v.ex_rs2);
    in_flight = (m_wait > 0) || v.dmem_req;
    if (in_flight && !v.dmem_ready) begin
      if (m_wait == MEM_TIMEOUT - 1) o.mem_abort = 1'b1;
      else                           o.freeze = 1'b1;
    end
    lu = v.ex_memread && v.ex_rd != 0 &&
         ((v.id_use_rs1 && v.id_rs1 == v.ex_rd) || (v.id_use_rs2 && v.id_rs2 == v.ex_rd));
    sb = MDU_ON && ((v.id_use_rs1 && v.id_rs1 != 0 && m_pend[v.id_rs1]) ||
                    (v.id_use_rs2 && v.id_rs2 != 0 && m_pend[v.id_rs2]) ||
                    (v.id_regwrite && v.id_rd != 0 && m_pend[v.id_rd]));
    if (o.freeze) begin
      o.stall_pc = 1'b1;
    end else if (v.br_taken) begin
      o.flush_if_id = 1'b1;
      o.flush_id_ex = 1'b1;
    end else if (lu || sb) begin
      o.stall_pc = 1'b1;
      o.bubble_id_ex = 1'b1;
    end
    o.stall_if_id = o.stall_pc;
    return o;
  endfunction

  task automatic model_update(input in_t v);
    out_t o;
    if (v.reset) begin
      m_wait = 0; m_tout = 0; m_cnt = 0; m_pend = '0;
      return;
    end
    o = model_out(v);
    if (o.mem_abort) begin
      m_tout = 1; m_wait = 0;
    end else if (o.freeze) m_wait++;
    else m_wait = 0;
    if (o.stall_pc && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    if (v.mdu_done && v.mdu_rd != 0) m_pend[v.mdu_rd] = 1'b0;
    if (v.mdu_issue && v.ex_rd != 0 && !o.freeze) m_pend[v.ex_rd] = 1'b1;
  endtask

  task automatic drive(input in_t v);
    reset = v.reset;
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_rd = v.id_rd;
    id_use_rs1 = v.id_use_rs1; id_use_rs2 = v.id_use_rs2; id_regwrite = v.id_regwrite;
    ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd;
    ex_regwrite = v.ex_regwrite; ex_memread = v.ex_memread;
    mem_rd = v.mem_rd; mem_regwrite = v.mem_regwrite;
    wb_rd = v.wb_rd; wb_regwrite = v.wb_regwrite;
    br_taken = v.br_taken; dmem_req = v.dmem_req; dmem_ready = v.dmem_ready;
    mdu_issue = v.mdu_issue; mdu_done = v.mdu_done; mdu_rd = v.mdu_rd;
  endtask

  function automatic out_t sample();
    out_t o;
    o.fwd_a = fwd_a; o.fwd_b = fwd_b;
    o.stall_pc = stall_pc; o.stall_if_id = stall_if_id; o.bubble_id_ex = bubble_id_ex;
    o.flush_if_id = flush_if_id; o.flush_id_ex = flush_id_ex;
    o.freeze = freeze; o.mem_abort = mem_abort; o.dmem_timeout = dmem_timeout;
    o.stall_cnt = stall_cnt;
    return o;
  endfunction

  // One cycle: apply at negedge, compare against the model, then advance the model at posedge.
  task automatic step(input in_t v, input string tag, output out_t got);
    @(negedge clk);
    drive(v);
    #2;
    got = sample();
    chk_all(tag, got, model_out(v));
    @(posedge clk);
    model_update(v);
  endtask

  task automatic do_reset();
    in_t  v = '0;
    out_t g;
    v.reset = 1'b1;
    step(v, "rst", g);
  endtask

  vec_t tv[$];

  task automatic add(input in_t i, input logic [1:0] fa, input logic [1:0] fb,
                     input logic st, input logic bu, input logic fl, input string nm);
    vec_t e;
    e.i = i; e.fa = fa; e.fb = fb; e.stall = st; e.bubble = bu; e.flush = fl; e.nm = nm;
    tv.push_back(e);
  endtask

  initial begin
    in_t  v;
    out_t g;

    v = '0;
    v.reset = 1'b1;
    drive(v);
    @(posedge clk);
    model_update(v);

    // Reset outputs with hazards and forwarding matches present on the inputs.
    v = '0; v.reset = 1'b1;
    v.ex_rs1 = 7; v.mem_rd = 7; v.mem_regwrite = 1; v.br_taken = 1;
    v.ex_memread = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1;
    step(v, "reset_out", g);
    chk("reset_flush_if_id", 32'(g.flush_if_id), 1);
    chk("reset_flush_id_ex", 32'(g.flush_id_ex), 1);
    chk("reset_fwd_a", 32'(g.fwd_a), 0);
    chk("reset_stall_pc", 32'(g.stall_pc), 0);
    v = '0;
    step(v, "post_reset", g);
    chk("reset_stall_cnt", 32'(g.stall_cnt), 0);
    chk("reset_dmem_timeout", 32'(g.dmem_timeout), 0);

    v = '0; v.ex_memread = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1;
    add(v, 2'b00, 2'b00, 1, 1, 0, "lu_rs1");
    v.ex_rd = 0; v.id_rs1 = 0;
    add(v, 2'b00, 2'b00, 0, 0, 0, "lu_rd0");
    v = '0; v.ex_memread = 1; v.ex_rd = 5; v.id_rs1 = 5;
    add(v, 2'b00, 2'b00, 0, 0, 0, "lu_unused_src");
    v = '0; v.ex_memread = 1; v.ex_rd = 12; v.id_rs2 = 12; v.id_use_rs2 = 1;
    add(v, 2'b00, 2'b00, 1, 1, 0, "lu_rs2");
    v = '0; v.mem_rd = 7; v.wb_rd = 7; v.mem_regwrite = 1; v.wb_regwrite = 1; v.ex_rs1 = 7;
    add(v, 2'b10, 2'b00, 0, 0, 0, "fwd_mem_prio");
    v.mem_regwrite = 0;
    add(v, 2'b01, 2'b00, 0, 0, 0, "fwd_wb");
    v = '0; v.ex_rs2 = 3; v.mem_rd = 3; v.mem_regwrite = 1; v.ex_rs1 = 4; v.wb_rd = 4; v.wb_regwrite = 1;
    add(v, 2'b01, 2'b10, 0, 0, 0, "fwd_b_mem");
    v = '0; v.mem_regwrite = 1; v.wb_regwrite = 1;
    add(v, 2'b00, 2'b00, 0, 0, 0, "fwd_r0");
    v = '0; v.ex_rs1 = 7; v.mem_rd = 7;
    add(v, 2'b00, 2'b00, 0, 0, 0, "fwd_no_regwrite");
    v = '0; v.ex_memread = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1; v.br_taken = 1;
    add(v, 2'b00, 2'b00, 0, 0, 1, "branch_over_lu");
    v = '0; v.br_taken = 1;
    add(v, 2'b00, 2'b00, 0, 0, 1, "branch_only");

    foreach (tv[n]) begin
      step(tv[n].i, tv[n].nm, g);
      chk({tv[n].nm, ".t_fwd_a"},  32'(g.fwd_a),        32'(tv[n].fa));
      chk({tv[n].nm, ".t_fwd_b"},  32'(g.fwd_b),        32'(tv[n].fb));
      chk({tv[n].nm, ".t_stall"},  32'(g.stall_pc),     32'(tv[n].stall));
      chk({tv[n].nm, ".t_bubble"}, 32'(g.bubble_id_ex), 32'(tv[n].bubble));
      chk({tv[n].nm, ".t_flush"},  32'(g.flush_id_ex),  32'(tv[n].flush));
    end

    // Three wait cycles, then ready.
    do_reset();
    v = '0; v.dmem_req = 1;
    for (int k = 0; k < 3; k++) begin
      step(v, "wait3", g);
      chk("wait3_freeze", 32'(g.freeze), 1);
    end
    v.dmem_ready = 1;
    step(v, "wait3_ready", g);
    chk("wait3_release", 32'(g.freeze), 0);
    chk("wait3_stall_cnt", 32'(g.stall_cnt), 3);

    // Timeout: 7 frozen cycles, abort on the 8th, sticky flag until reset.
    do_reset();
    v = '0; v.dmem_req = 1;
    for (int k = 0; k < MEM_TIMEOUT - 1; k++) begin
      step(v, "tmo_wait", g);
      chk("tmo_freeze", 32'(g.freeze), 1);
      chk("tmo_no_abort", 32'(g.mem_abort), 0);
    end
    step(v, "tmo_abort", g);
    chk("tmo_abort_pulse", 32'(g.mem_abort), 1);
    chk("tmo_abort_nofreeze", 32'(g.freeze), 0);
    chk("tmo_stall_cnt", 32'(g.stall_cnt), 7);
    v = '0;
    for (int k = 0; k < 2; k++) begin
      step(v, "tmo_after", g);
      chk("tmo_abort_single", 32'(g.mem_abort), 0);
      chk("tmo_sticky", 32'(g.dmem_timeout), 1);
    end
    do_reset();
    step(v, "tmo_cleared", g);
    chk("tmo_cleared_flag", 32'(g.dmem_timeout), 0);

    // Ready arriving on the timeout cycle wins.
    v = '0; v.dmem_req = 1;
    for (int k = 0; k < MEM_TIMEOUT - 1; k++) step(v, "rdy_last_wait", g);
    v.dmem_ready = 1;
    step(v, "rdy_last", g);
    chk("rdy_last_no_abort", 32'(g.mem_abort), 0);
    v = '0;
    step(v, "rdy_last_after", g);
    chk("rdy_last_no_flag", 32'(g.dmem_timeout), 0);

    // Immediate ready never freezes.
    v = '0; v.dmem_req = 1; v.dmem_ready = 1;
    step(v, "imm_ready", g);
    chk("imm_ready_freeze", 32'(g.freeze), 0);
    v = '0;
    step(v, "imm_ready_next", g);
    chk("imm_ready_next_freeze", 32'(g.freeze), 0);

    // Branch held off by freeze.
    v = '0; v.dmem_req = 1; v.br_taken = 1;
    for (int k = 0; k < 2; k++) begin
      step(v, "br_frz", g);
      chk("br_frz_noflush", 32'(g.flush_if_id), 0);
      chk("br_frz_stall", 32'(g.stall_pc), 1);
    end
    v.dmem_ready = 1;
    step(v, "br_release", g);
    chk("br_release_flush", 32'(g.flush_id_ex), 1);

    // Reset in the middle of a wait.
    v = '0; v.dmem_req = 1;
    step(v, "rst_wait0", g);
    step(v, "rst_wait1", g);
    v.reset = 1;
    step(v, "rst_mid", g);
    chk("rst_mid_abort", 32'(g.mem_abort), 0);
    chk("rst_mid_freeze", 32'(g.freeze), 0);
    v = '0;
    step(v, "rst_mid_after", g);
    chk("rst_mid_after_freeze", 32'(g.freeze), 0);
    chk("rst_mid_after_abort", 32'(g.mem_abort), 0);

    // Scoreboard RAW and WAW.
    do_reset();
    v = '0; v.mdu_issue = 1; v.ex_rd = 9;
    step(v, "mdu_issue", g);
    chk("mdu_issue_nostall", 32'(g.stall_pc), 0);
    v = '0; v.id_rs1 = 9; v.id_use_rs1 = 1;
    for (int k = 0; k < 2; k++) begin
      step(v, "mdu_raw", g);
      chk("mdu_raw_stall", 32'(g.stall_pc), 32'(MDU_ON));
    end
    v.mdu_done = 1; v.mdu_rd = 9;
    step(v, "mdu_done", g);
    chk("mdu_done_stall", 32'(g.stall_pc), 32'(MDU_ON));
    v = '0; v.id_rs1 = 9; v.id_use_rs1 = 1;
    step(v, "mdu_clear", g);
    chk("mdu_clear_nostall", 32'(g.stall_pc), 0);
    v = '0; v.mdu_issue = 1; v.ex_rd = 10; v.mdu_done = 1; v.mdu_rd = 10;
    step(v, "mdu_setwins", g);
    v = '0; v.id_rd = 10; v.id_regwrite = 1;
    step(v, "mdu_waw", g);
    chk("mdu_waw_stall", 32'(g.bubble_id_ex), 32'(MDU_ON));

    // Counter saturation under a held load-use stall.
    do_reset();
    v = '0; v.ex_memread = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1;
    for (int k = 0; k < 70; k++) step(v, "sat", g);
    chk("sat_stall_cnt", 32'(g.stall_cnt), (1 << CNT_W) - 1);

    // Randomised traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v = '0;
      v.reset = ($urandom_range(0, 99) == 0);
      v.id_rs1 = RA_W'($urandom_range(0, 3)); v.id_rs2 = RA_W'($urandom_range(0, 3));
      v.id_rd  = RA_W'($urandom_range(0, 3));
      v.id_use_rs1 = 1'($urandom_range(0, 1)); v.id_use_rs2 = 1'($urandom_range(0, 1));
      v.id_regwrite = 1'($urandom_range(0, 1));
      v.ex_rs1 = RA_W'($urandom_range(0, 3)); v.ex_rs2 = RA_W'($urandom_range(0, 3));
      v.ex_rd  = RA_W'($urandom_range(0, 3));
      v.ex_regwrite = 1'($urandom_range(0, 1)); v.ex_memread = ($urandom_range(0, 3) == 0);
      v.mem_rd = RA_W'($urandom_range(0, 3)); v.mem_regwrite = 1'($urandom_range(0, 1));
      v.wb_rd  = RA_W'($urandom_range(0, 3)); v.wb_regwrite = 1'($urandom_range(0, 1));
      v.br_taken = ($urandom_range(0, 6) == 0);
      v.dmem_req = ($urandom_range(0, 4) == 0);
      v.dmem_ready = ($urandom_range(0, 2) == 0);
      v.mdu_issue = ($urandom_range(0, 4) == 0);
      v.mdu_done = ($urandom_range(0, 4) == 0);
      v.mdu_rd = RA_W'($urandom_range(0, 3));
      step(v, "rand", g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, got no completion expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
